// File: rtl/aes128_inv_if.sv
// Request/result bundle for the iterative AES-128 inverse cipher core.
interface aes128_inv_if;
    logic         start;
    logic [127:0] ciphertext;
    logic [127:0] key;
    logic         fault_inject;
    logic [127:0] plaintext;
    logic         done;
    logic         busy;

    modport master (
        output start, ciphertext, key, fault_inject,
        input  plaintext, done, busy
    );

    modport slave (
        input  start, ciphertext, key, fault_inject,
        output plaintext, done, busy
    );
endinterface

// File: rtl/aes128_inv_core.sv
// Iterative AES-128 inverse cipher, one round per cycle, round keys derived on the fly.
// Optional last-key/rk10 cache enabled by defining AES_DEC_KEY_CACHE_EN.
module aes128_inv_core (
    input  logic        clk,
    input  logic        rst_n,
    aes128_inv_if.slave bus
);
    localparam int unsigned BLK_W = 128;
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(9);

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        KEXP = 2'd1,
        DEC  = 2'd2
    } fsm_t;

    // Table entry x sits at bits [8*(255-x) +: 8]; ~x gives 255-x.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [CNT_W-1:0] idx);
        logic [7:0] rc;
        case (idx)
            4'd0:    rc = 8'h01;
            4'd1:    rc = 8'h02;
            4'd2:    rc = 8'h04;
            4'd3:    rc = 8'h08;
            4'd4:    rc = 8'h10;
            4'd5:    rc = 8'h20;
            4'd6:    rc = 8'h40;
            4'd7:    rc = 8'h80;
            4'd8:    rc = 8'h1b;
            4'd9:    rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
        return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
    endfunction

    function automatic logic [BLK_W-1:0] expand_step(input logic [BLK_W-1:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        {w0, w1, w2, w3} = k;
        w0 = w0 ^ sub_rot_word(w3) ^ {rc, 24'h000000};
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // Undo one expansion step: recover round key i from round key i+1.
    function automatic logic [BLK_W-1:0] inv_expand_step(input logic [BLK_W-1:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        {w0, w1, w2, w3} = k;
        w3 = w3 ^ w2;
        w2 = w2 ^ w1;
        w1 = w1 ^ w0;
        w0 = w0 ^ sub_rot_word(w3) ^ {rc, 24'h000000};
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // GF(2^8) multiply by a 4-bit constant (9, b, d, e for InvMixColumns).
    function automatic logic [7:0] gf_mul_k(input logic [7:0] a, input logic [3:0] k);
        logic [7:0] x2, x4, x8;
        x2 = xtime(a);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return (k[3] ? x8 : 8'h00) ^ (k[2] ? x4 : 8'h00) ^ (k[1] ? x2 : 8'h00) ^ (k[0] ? a : 8'h00);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {gf_mul_k(a0, 4'he) ^ gf_mul_k(a1, 4'hb) ^ gf_mul_k(a2, 4'hd) ^ gf_mul_k(a3, 4'h9),
                gf_mul_k(a0, 4'h9) ^ gf_mul_k(a1, 4'he) ^ gf_mul_k(a2, 4'hb) ^ gf_mul_k(a3, 4'hd),
                gf_mul_k(a0, 4'hd) ^ gf_mul_k(a1, 4'h9) ^ gf_mul_k(a2, 4'he) ^ gf_mul_k(a3, 4'hb),
                gf_mul_k(a0, 4'hb) ^ gf_mul_k(a1, 4'hd) ^ gf_mul_k(a2, 4'h9) ^ gf_mul_k(a3, 4'he)};
    endfunction

    // InvShiftRows + InvSubBytes + AddRoundKey, then InvMixColumns unless final round.
    function automatic logic [BLK_W-1:0] inv_round(input logic [BLK_W-1:0] s, input logic [BLK_W-1:0] k,
                                                   input logic last);
        logic [0:15][7:0] in_b, ak;
        logic [0:3][31:0] ak_col, mc_col;
        in_b = s;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                ak[4'(4 * c + r)] = inv_sbox(in_b[4'(4 * ((c + 4 - r) % 4) + r)]) ^ k[7'(120 - 32 * c - 8 * r) +: 8];
            end
        end
        ak_col = ak;
        for (int c = 0; c < 4; c++) begin
            mc_col[2'(c)] = inv_mix_col(ak_col[2'(c)]);
        end
        return last ? BLK_W'(ak_col) : BLK_W'(mc_col);
    endfunction

    fsm_t             fsm_q, fsm_nxt;
    logic [BLK_W-1:0] state_q, state_nxt;
    logic [BLK_W-1:0] rk_q, rk_nxt;
    logic [BLK_W-1:0] ct_q, ct_nxt;
    logic [BLK_W-1:0] pt_q, pt_nxt;
    logic [CNT_W-1:0] rcnt_q, rcnt_nxt;
    logic             done_q, done_nxt;
    logic             busy_q, busy_nxt;

    logic [BLK_W-1:0] rk_fwd, rk_inv, round_out;

`ifdef AES_DEC_KEY_CACHE_EN
    logic [BLK_W-1:0] cache_key_q, cache_key_nxt;
    logic [BLK_W-1:0] cache_rk10_q, cache_rk10_nxt;
    logic             cache_valid_q, cache_valid_nxt;
    logic             cache_hit;

    assign cache_hit = cache_valid_q && (bus.key == cache_key_q);
`endif

    assign rk_fwd    = expand_step(rk_q, rcon(rcnt_q));
    assign rk_inv    = inv_expand_step(rk_q, rcon(rcnt_q));
    assign round_out = inv_round(state_q, rk_inv, rcnt_q == '0) ^ BLK_W'(bus.fault_inject);

    // Next-state and datapath control.
    always_comb begin
        fsm_nxt   = fsm_q;
        state_nxt = state_q;
        rk_nxt    = rk_q;
        ct_nxt    = ct_q;
        pt_nxt    = pt_q;
        rcnt_nxt  = rcnt_q;
        done_nxt  = 1'b0;
        busy_nxt  = busy_q;
`ifdef AES_DEC_KEY_CACHE_EN
        cache_key_nxt   = cache_key_q;
        cache_rk10_nxt  = cache_rk10_q;
        cache_valid_nxt = cache_valid_q;
`endif
        case (fsm_q)
            IDLE: begin
                if (bus.start) begin
                    ct_nxt   = bus.ciphertext;
                    rk_nxt   = bus.key;
                    rcnt_nxt = '0;
                    busy_nxt = 1'b1;
                    fsm_nxt  = KEXP;
`ifdef AES_DEC_KEY_CACHE_EN
                    if (cache_hit) begin
                        state_nxt = bus.ciphertext ^ cache_rk10_q;
                        rk_nxt    = cache_rk10_q;
                        rcnt_nxt  = LAST_STEP;
                        fsm_nxt   = DEC;
                    end else begin
                        // Cache entry is rebuilt during this run and only trusted at completion.
                        cache_key_nxt   = bus.key;
                        cache_valid_nxt = 1'b0;
                    end
`endif
                end
            end
            KEXP: begin
                rk_nxt   = rk_fwd;
                rcnt_nxt = rcnt_q + CNT_W'(1);
                if (rcnt_q == LAST_STEP) begin
                    state_nxt = ct_q ^ rk_fwd;
                    rcnt_nxt  = LAST_STEP;
                    fsm_nxt   = DEC;
`ifdef AES_DEC_KEY_CACHE_EN
                    cache_rk10_nxt = rk_fwd;
`endif
                end
            end
            DEC: begin
                rk_nxt    = rk_inv;
                state_nxt = round_out;
                rcnt_nxt  = rcnt_q - CNT_W'(1);
                if (rcnt_q == '0) begin
                    pt_nxt   = round_out;
                    done_nxt = 1'b1;
                    busy_nxt = 1'b0;
                    rcnt_nxt = '0;
                    fsm_nxt  = IDLE;
`ifdef AES_DEC_KEY_CACHE_EN
                    cache_valid_nxt = 1'b1;
`endif
                end
            end
            default: fsm_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            rk_q    <= '0;
            ct_q    <= '0;
            pt_q    <= '0;
            rcnt_q  <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef AES_DEC_KEY_CACHE_EN
            cache_key_q   <= '0;
            cache_rk10_q  <= '0;
            cache_valid_q <= 1'b0;
`endif
        end else begin
            fsm_q   <= fsm_nxt;
            state_q <= state_nxt;
            rk_q    <= rk_nxt;
            ct_q    <= ct_nxt;
            pt_q    <= pt_nxt;
            rcnt_q  <= rcnt_nxt;
            done_q  <= done_nxt;
            busy_q  <= busy_nxt;
`ifdef AES_DEC_KEY_CACHE_EN
            cache_key_q   <= cache_key_nxt;
            cache_rk10_q  <= cache_rk10_nxt;
            cache_valid_q <= cache_valid_nxt;
`endif
        end
    end

    assign bus.plaintext = pt_q;
    assign bus.done      = done_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_aes128_inv_core.sv
// Self-checking bench for aes128_inv_core: FIPS-197 vectors, timing, fault hook, reset abort, random blocks.
module tb_aes128_inv_core;
`ifdef AES_DEC_KEY_CACHE_EN
    localparam bit CACHE_EN = 1'b1;
`else
    localparam bit CACHE_EN = 1'b0;
`endif

    localparam logic [127:0] C1K = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1P = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] BK  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] BC  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] BP  = 128'h3243f6a8885a308d313198a2e0370734;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    logic [7:0]   sb  [256];
    logic [7:0]   isb [256];
    bit           model_cv = 1'b0;
    logic [127:0] model_ck = '0;

    aes128_inv_if bus();

    aes128_inv_core dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-boxes derived from the field inverse and affine map rather than copied tables.
    task automatic build_tables();
        logic [7:0] a, inv, s;
        for (int x = 0; x < 256; x++) begin
            a = 8'(x);
            inv = 8'h01;
            for (int e = 0; e < 254; e++) inv = gmul(inv, a);
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                    ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sb[x]  = s;
            isb[s] = a;
        end
    endtask

    function automatic logic [127:0] ref_dec(input logic [127:0] k, input logic [127:0] c);
        logic [31:0]  w [44];
        logic [31:0]  tmp;
        logic [7:0]   rc, acc;
        logic [7:0]   st [4][4];
        logic [7:0]   tt [4][4];
        logic [7:0]   coef [4];
        logic [127:0] res;
        coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32 * i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i - 1];
            if (i % 4 == 0) begin
                tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h000000};
                rc  = gmul(rc, 8'h02);
            end
            w[i] = w[i - 4] ^ tmp;
        end
        for (int c2 = 0; c2 < 4; c2++)
            for (int r = 0; r < 4; r++)
                st[r][c2] = c[127 - 8 * (r + 4 * c2) -: 8] ^ w[40 + c2][31 - 8 * r -: 8];
        for (int rnd = 9; rnd >= 0; rnd--) begin
            for (int c2 = 0; c2 < 4; c2++)
                for (int r = 0; r < 4; r++)
                    tt[r][c2] = isb[st[r][(c2 - r + 4) % 4]] ^ w[4 * rnd + c2][31 - 8 * r -: 8];
            for (int c2 = 0; c2 < 4; c2++)
                for (int r = 0; r < 4; r++) begin
                    acc = 8'h00;
                    for (int i = 0; i < 4; i++) acc = acc ^ gmul(tt[i][c2], coef[(i - r + 4) % 4]);
                    st[r][c2] = (rnd == 0) ? tt[r][c2] : acc;
                end
        end
        for (int c2 = 0; c2 < 4; c2++)
            for (int r = 0; r < 4; r++)
                res[127 - 8 * (r + 4 * c2) -: 8] = st[r][c2];
        return res;
    endfunction

    // One operation: start pulse at the current negedge, returns at the negedge showing done.
    // f_mode: 0 none, 1 fault on the final edge only, 2 fault on edges E1..E10.
    task automatic run_op(input string tag, input logic [127:0] k_in, input logic [127:0] c_in,
                          input logic [127:0] exp_pt, input int f_mode, input int s1, input int s2);
        int exp_lat;
        int lat;
        bit busy_ok;
        exp_lat = (CACHE_EN && model_cv && (k_in == model_ck)) ? 10 : 20;
        lat = -1;
        busy_ok = 1'b1;
        bus.start = 1'b1;
        bus.key = k_in;
        bus.ciphertext = c_in;
        bus.fault_inject = 1'b0;
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk);
            if (bus.done) begin
                lat = k - 1;
                break;
            end
            if (!bus.busy) busy_ok = 1'b0;
            bus.start = (k == s1) || (k == s2);
            bus.fault_inject = (f_mode == 1) ? (k == exp_lat) : ((f_mode == 2) ? (k <= 10) : 1'b0);
            if (k == 1) begin
                bus.key = rnd128();
                bus.ciphertext = rnd128();
            end
        end
        bus.start = 1'b0;
        bus.fault_inject = 1'b0;
        check({tag, ":latency"}, 128'(lat), 128'(exp_lat));
        check({tag, ":plaintext"}, bus.plaintext, exp_pt);
        check({tag, ":busy_during"}, 128'(busy_ok), 128'(1));
        check({tag, ":busy_at_done"}, 128'(bus.busy), 128'(0));
        model_cv = 1'b1;
        model_ck = k_in;
    endtask

    initial begin
        int dones;
        logic [127:0] rk, rc;
        build_tables();
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.key = '0;
        bus.ciphertext = '0;
        bus.fault_inject = 1'b0;
        repeat (2) @(negedge clk);
        check("reset:plaintext", bus.plaintext, '0);
        check("reset:done", 128'(bus.done), '0);
        check("reset:busy", 128'(bus.busy), '0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("c1", C1K, C1C, C1P, 0, -1, -1);
        @(negedge clk);
        check("c1:done_one_cycle", 128'(bus.done), '0);
        run_op("c1_repeat", C1K, C1C, C1P, 0, -1, -1);

        // Back-to-back: second start issued in the done cycle.
        run_op("b_first", BK, BC, BP, 0, -1, -1);
        run_op("c1_b2b", C1K, C1C, C1P, 0, -1, -1);

        run_op("c1_fault_last", C1K, C1C, C1P ^ 128'h1, 1, -1, -1);

        run_op("b_spurious_start", BK, BC, BP, 0, 5, 12);
        dones = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        check("b_spurious_start:extra_done", 128'(dones), '0);

        run_op("c1_fault_kexp", C1K, C1C, C1P, 2, -1, -1);

        // Reset abort part-way through an operation.
        @(negedge clk);
        bus.start = 1'b1;
        bus.key = C1K;
        bus.ciphertext = C1C;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort:busy", 128'(bus.busy), '0);
        check("abort:done", 128'(bus.done), '0);
        check("abort:plaintext", bus.plaintext, '0);
        @(negedge clk);
        rst_n = 1'b1;
        model_cv = 1'b0;
        dones = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        check("abort:no_done", 128'(dones), '0);
        run_op("c1_after_abort", C1K, C1C, C1P, 0, -1, -1);

        rk = '0;
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) rk = rnd128();
            rc = rnd128();
            @(negedge clk);
            run_op($sformatf("rnd%0d", i), rk, rc, ref_dec(rk, rc) ^ ((i == 5) ? 128'h1 : 128'h0),
                   (i == 5) ? 1 : 0, -1, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/aes128_inv_core.md
Name: aes128_inv_core

Overview:
- Iterative AES-128 inverse cipher (FIPS-197 decryption). Counterpart to the encryption core used in the hardened encryption top.
- Interface mirrors the encryption core, including a `fault_inject` hook, so a hardened decryption top can run two copies in lockstep and compare their results.
- Round keys are computed on the fly: forward key expansion first, then the inverse key schedule during decryption. No round-key RAM.

Parameters:
- None. Key size fixed at 128 bits, Nr = 10.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only while idle
- ciphertext  input  128  block to decrypt; byte 0 = bits [127:120] (FIPS-197 order)
- key  input  128  cipher key (round key 0)
- fault_inject  input  1  test hook; XORs 128'h1 into the state register at any decrypt-round edge where high
- plaintext  output  128  result register
- done  output  1  one-cycle pulse: plaintext valid
- busy  output  1  operation in progress

Behaviour:
- Reset (async, rst_n=0): FSM to IDLE; plaintext=0, done=0, busy=0; state, round-key and round-counter registers cleared.
- FSM states: IDLE, KEXP, DEC.
- IDLE:
  - On edge E0 with start=1: latch ciphertext and key; rk <= key; rcnt <= 0; busy <= 1; go to KEXP.
  - start=0: remain.
- KEXP (edges E1..E10):
  - rk <= ExpandStep(rk, Rcon[rcnt]), where Rcon = 01,02,04,08,10,20,40,80,1b,36.
  - At E10: state <= ct_latched ^ rk10 (the value being computed); go to DEC, rcnt <= 9.
- DEC (edges E11..E20):
  - Each edge: rk <= InvExpandStep(rk, Rcon[rcnt]), yielding round key rcnt.
  - Rounds 9..1: state <= InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(state)), rk_rcnt)).
  - Round 0 (E20): no InvMixColumns; plaintext <= result; done <= 1; busy <= 0; go to IDLE.
  - fault_inject is applied after the round function on that edge, including E20.
- Latency: start edge to done-high edge is exactly 20 cycles. The next start is accepted on the edge where done is high.
- done: high for exactly one cycle. plaintext holds its value until the next completion or reset.
- start while busy: ignored. Inputs are not re-sampled mid-operation; ciphertext and key may change freely after E0.
- fault_inject:
  - Ignored in IDLE and KEXP.
  - No internal detection; comparison belongs to the enclosing top.
- Reset asserted mid-operation: immediate abort. No done pulse, outputs return to reset values, result is discarded.
- S-box: inverse S-box used for the data path; forward S-box used for key expansion (SubWord). All combinational LUTs. One round per cycle.
- Rcon indexing wraps nowhere: rcnt range 0..9 is enforced by the FSM.

Optional Feature:
- Macro: AES_DEC_KEY_CACHE_EN
- Defined:
  - Adds a 128-bit cached key, a 128-bit cached rk10, and a cache_valid bit (reset 0).
  - At completion, the cache is loaded with the latched key and the rk10 from that run; cache_valid <= 1.
  - On accepted start with cache_valid=1 and key == cached key:
    - Skip KEXP.
    - At E0: state <= ciphertext ^ cached rk10; rk <= cached rk10; go directly to DEC.
    - done at E10: latency 10 cycles.
  - Miss: 20-cycle path as above.
- Undefined:
  - No cache storage.
  - Latency always 20 cycles.

Test Plan:
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a, 1-cycle start -> done exactly 20 cycles later, plaintext 00112233445566778899aabbccddeeff, busy high for those 20 cycles.
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32 -> plaintext 3243f6a8885a308d313198a2e0370734. Issue back-to-back, with the second start in the cycle done is high, and ciphertext/key changed at E1 -> both results correct.
- C.1 vector with fault_inject high only during the cycle before the final edge (E20) -> plaintext 00112233445566778899aabbccddeefe. With fault_inject held high only during KEXP -> correct plaintext.
- start pulsed at cycles 5 and 12 after the first start -> ignored; exactly one done; no change in latency.
- rst_n low at cycle 8 of an operation -> busy=0, done=0, plaintext=0 immediately. No done afterwards. A new C.1 run then completes correctly.
- With AES_DEC_KEY_CACHE_EN:
  - C.1 run (20 cycles), then same key with ct of App. C.1 again -> done after 10 cycles, correct plaintext.
  - Then App. B key -> 20 cycles.
